mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly downstream of the memory data selector.
- Captures the selected 16-bit write word, or a read request, and drives a multi-cycle ack-based memory bus.
- Latches returned read data into the memory data register (MDR) for the datapath.
- Provides busy/done/err status to the control unit, with a bounded wait (timeout).

Parameters:
- DATA_W, 16, data bus and MDR width
- ADDR_W, 16, memory address width
- TIMEOUT, 15, maximum cycles to wait for mem_ack after the request is asserted; minimum 1

Ports:
- CLK  in  1  single system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  control pulse: begin access; sampled only when accepting
- we  in  1  1 = write, 0 = read; sampled with start
- addr  in  ADDR_W  access address; sampled with start
- wdata  in  DATA_W  write word from the memory data selector output; sampled with start
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  registered copy of we
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completion strobe, one cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ack = 1
- mdr  out  DATA_W  memory data register
- busy  out  1  access in flight
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when the access timed out

Behaviour:
- Reset (async, Reset_n = 0):
  - state = IDLE.
  - mem_req, mem_we, busy, done, err = 0.
  - mem_addr, mem_wdata, mdr = 0.
  - Timeout counter = 0.
  - Reset mid-access drops mem_req immediately; the aborted access produces no done.
- States are IDLE, REQ, DONE. All outputs are registered.
- Accepting states: IDLE and DONE.
  - start = 1 in an accepting state: capture we/addr/wdata into mem_we/mem_addr/mem_wdata.
  - Next cycle: mem_req = 1, busy = 1, counter = 0, state = REQ.
- start while in REQ is ignored; captured registers are unchanged and no queuing occurs.
- REQ state:
  - Each cycle without mem_ack, the counter increments.
  - mem_ack = 1: next cycle mem_req = 0, busy = 0, done = 1, state = DONE.
    - Read: mdr <= mem_rdata on the ack edge.
    - Write: mdr unchanged.
  - Counter reaches TIMEOUT - 1 with no ack: next cycle mem_req = 0, busy = 0, done = 1, err = 1, state = DONE; mdr unchanged.
  - Ack arriving in the same cycle as the counter limit counts as success: ack wins, err = 0.
- Minimum latency: start at edge N, mem_req high from N+1; ack sampled at edge N+1 gives done high during N+1..N+2.
- DONE lasts exactly one cycle.
  - start = 1: back-to-back access (done = 1 and the new capture coincide); next state is REQ.
  - Otherwise: IDLE.
- mem_ack outside REQ is ignored and does not alter mdr.
- mdr holds its value indefinitely between reads.
- The counter is ceil(log2(TIMEOUT + 1)) bits and saturates rather than wrapping.

Decomposition:
- Shared package mem_pkg:
  - State encoding constants IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2.
  - DATA_W / ADDR_W defaults.
- One natural sub-module: mem_timeout_counter.
  - Inputs: clear, enable. Output: expired.
  - Parameterised by TIMEOUT.
  - Async active-low reset on the same Reset_n.
- The FSM, capture registers and MDR stay in mem_access_unit.

Test Plan:
- Read, ack after 3 cycles:
  - Stimulus: start = 1, we = 0, addr = 16'h0040; mem_rdata = 16'hBEEF with ack 3 cycles after mem_req rises.
  - Response: mem_addr = 16'h0040, mdr = 16'hBEEF, one done pulse, err = 0, busy high for 3 cycles.
- Write, ack in the first REQ cycle:
  - Stimulus: start = 1, we = 1, addr = 16'h0012, wdata = 16'h1234, ack on the first REQ cycle.
  - Response: mem_we = 1, mem_wdata = 16'h1234, done 1 cycle later, mdr keeps its prior value 16'hBEEF.
- Timeout:
  - Stimulus: TIMEOUT = 15, read with no ack.
  - Response: mem_req drops after exactly 15 REQ cycles; done = err = 1 for one cycle; mdr unchanged.
- Busy and back-to-back handling:
  - Stimulus: start pulsed during REQ with addr = 16'hFFFF; later start held in the DONE cycle with addr = 16'h0002.
  - Response: the REQ-time start is ignored and mem_addr stays at the original value; the DONE-cycle start produces a new REQ the next cycle with mem_addr = 16'h0002.
- Reset mid-access:
  - Stimulus: Reset_n pulled low asynchronously (between edges) during REQ.
  - Response: mem_req, busy, mdr = 0 immediately; no done pulse after release; a fresh start works normally.
- Ack at the timeout boundary:
  - Stimulus: mem_ack on the 15th REQ cycle with mem_rdata = 16'hA5A5.
  - Response: mdr = 16'hA5A5, done = 1, err = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared widths and FSM state encoding for the memory access unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
// ============================================================================
// Module   : mem_timeout_counter
// Purpose  : Saturating wait counter; flags expiry on the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count >= c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Captures a read/write access and runs it on an ack-based bus,
//            latching read data into the MDR with a bounded wait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_expired;
    logic                w_timeout;
    logic                w_finish;

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_timeout = (r_state == REQ) && !mem_ack && w_expired;
    // Ack takes priority over expiry when both land in the same cycle.
    assign w_finish  = (r_state == REQ) && (mem_ack || w_expired);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .clear   (w_accept),
        .enable  ((r_state == REQ) && !mem_ack),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? REQ : IDLE;
            REQ:     w_state_nxt = w_finish ? DONE : REQ;
            DONE:    w_state_nxt = w_accept ? REQ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mdr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt == REQ);
            r_busy    <= (w_state_nxt == REQ);
            r_done    <= w_finish;
            r_err     <= w_timeout;
            if (w_accept) begin
                r_mem_we    <= we;
                r_mem_addr  <= addr;
                r_mem_wdata <= wdata;
            end
            if ((r_state == REQ) && mem_ack && !r_mem_we) begin
                r_mdr <= mem_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mdr       = r_mdr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire
